// File: rtl/fetch_ctrl_if.sv
// Fetch-side bus bundle: imem req/gnt/rvalid channel plus the valid/ready
// channel toward decode. master = fetch sequencer, slave = imem/decode side.
interface fetch_ctrl_if #(
  parameter int unsigned PC_WIDTH    = 32,
  parameter int unsigned INSTR_WIDTH = 32
);
  logic                   imem_req;
  logic [PC_WIDTH-1:0]    imem_addr;
  logic                   imem_gnt;
  logic                   imem_rvalid;
  logic [INSTR_WIDTH-1:0] imem_rdata;

  logic                   if_valid;
  logic [PC_WIDTH-1:0]    if_pc;
  logic [INSTR_WIDTH-1:0] if_instr;
  logic                   if_ready;

  modport master (
    output imem_req, imem_addr, if_valid, if_pc, if_instr,
    input  imem_gnt, imem_rvalid, imem_rdata, if_ready
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_pc, if_instr,
    output imem_gnt, imem_rvalid, imem_rdata, if_ready
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, single-outstanding imem
// request, hands {pc,instr} to decode, squashes on redirect.
// Optional FETCH_PERF_EN adds saturating fetch/stall performance counters.
module fetch_ctrl #(
  parameter int unsigned         PC_WIDTH    = 32,
  parameter int unsigned         INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                go,
  input  logic                redirect,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  fetch_ctrl_if.master        bus,
  output logic                busy
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]         perf_fetch_cnt,
  output logic [31:0]         perf_stall_cnt
`endif
);

  localparam int unsigned PERF_W = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_FLUSH
  } state_t;

  state_t                 state;
  state_t                 state_next;
  state_t                 resume;
  logic [PC_WIDTH-1:0]    pc;
  logic [PC_WIDTH-1:0]    pc_next;
  logic [PC_WIDTH-1:0]    target;
  logic                   capture;
  logic                   valid_next;
  logic                   req_q;
  logic                   busy_q;
  logic                   valid_q;
  logic [PC_WIDTH-1:0]    if_pc_q;
  logic [INSTR_WIDTH-1:0] if_instr_q;

  // Redirect targets are word aligned; the low two bits are dropped.
  assign target = redirect_pc & ~PC_WIDTH'(3);
  assign resume = go ? S_REQ : S_IDLE;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state, PC update and decode-register load decisions
  always_comb begin
    state_next = state;
    pc_next    = pc;
    capture    = 1'b0;
    valid_next = valid_q;
    case (state)
      S_IDLE: begin
        if (redirect) pc_next = target;
        if (go)       state_next = S_REQ;
      end
      S_REQ: begin
        if (redirect) begin
          pc_next = target;
          if (bus.imem_gnt) state_next = S_FLUSH;
        end else if (bus.imem_gnt) begin
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect) begin
          pc_next    = target;
          state_next = bus.imem_rvalid ? resume : S_FLUSH;
        end else if (bus.imem_rvalid) begin
          capture    = 1'b1;
          pc_next    = pc + PC_WIDTH'(4);
          valid_next = 1'b1;
          state_next = S_HOLD;
        end
      end
      S_HOLD: begin
        if (redirect || bus.if_ready) begin
          valid_next = 1'b0;
          state_next = resume;
          if (redirect) pc_next = target;
        end
      end
      S_FLUSH: begin
        // The squashed response still has to drain before a new request.
        if (redirect)         pc_next = target;
        if (bus.imem_rvalid)  state_next = resume;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Datapath and registered outputs, derived from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= RESET_PC;
      req_q      <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      if_pc_q    <= '0;
      if_instr_q <= '0;
    end else begin
      pc      <= pc_next;
      req_q   <= (state_next == S_REQ);
      busy_q  <= (state_next != S_IDLE);
      valid_q <= valid_next;
      if (capture) begin
        if_pc_q    <= pc;
        if_instr_q <= bus.imem_rdata;
      end
    end
  end

  assign bus.imem_req  = req_q;
  assign bus.imem_addr = pc;
  assign bus.if_valid  = valid_q;
  assign bus.if_pc     = if_pc_q;
  assign bus.if_instr  = if_instr_q;
  assign busy          = busy_q;

`ifdef FETCH_PERF_EN
  logic              fetch_evt;
  logic              stall_evt;
  logic [PERF_W-1:0] fetch_cnt_q;
  logic [PERF_W-1:0] stall_cnt_q;

  assign fetch_evt = valid_q & bus.if_ready;
  assign stall_evt = ((state == S_REQ)  && !bus.imem_gnt) ||
                     ((state == S_WAIT) && !bus.imem_rvalid);

  // Saturating event counters
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (fetch_evt && (fetch_cnt_q != '1)) fetch_cnt_q <= fetch_cnt_q + PERF_W'(1);
      if (stall_evt && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + PERF_W'(1);
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`endif

  a_req_only_in_req: assert property (@(posedge clk) disable iff (rst)
    bus.imem_req |-> (state == S_REQ));
  a_valid_only_in_hold: assert property (@(posedge clk) disable iff (rst)
    bus.if_valid |-> (state == S_HOLD));

endmodule
